// File: rtl/module_top_deco_gray_multi.sv
// Gray/binary switch decoder with double-dabble BCD conversion and a
// multiplexed 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module module_top_deco_gray_multi #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DIGITS          = 3,
  parameter int unsigned INPUT_REFRESH   = 2700000,
  parameter int unsigned DISPLAY_REFRESH = 27000
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic [WIDTH-1:0]  codigo_gray_pi,
  input  logic              mode_pi,
  output logic [DIGITS-1:0] anodo_po,
  output logic [6:0]        catodo_po,
  output logic [WIDTH-1:0]  codigo_bin_led_po,
  output logic              bcd_valid_po
);

  localparam int unsigned SampW = $clog2(INPUT_REFRESH);
  localparam int unsigned ScanW = (DISPLAY_REFRESH > 1) ? $clog2(DISPLAY_REFRESH) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BitW  = $clog2(WIDTH);
  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned ShW   = BcdW + WIDTH;

  localparam logic [SampW-1:0] SampMax = SampW'(INPUT_REFRESH - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(DISPLAY_REFRESH - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(DIGITS - 1);
  localparam logic [BitW-1:0]  BitMax  = BitW'(WIDTH - 1);
  localparam logic [6:0]       SegBlank = 7'h7F;
  localparam logic [6:0]       SegZero  = 7'b1000000;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [ShW-1:0] dabble_step(input logic [ShW-1:0] s);
    logic [ShW-1:0] t;
    t = s;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (t[WIDTH+4*d +: 4] >= 4'd5) begin
        t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

  // Segments {g,f,e,d,c,b,a}, active-low; codes 10..15 blank.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  logic [WIDTH:0]      sync1_q, sync2_q;
  logic [SampW-1:0]    samp_cnt_q;
  logic                tick;
  logic [WIDTH-1:0]    bin_q;
  logic [WIDTH-1:0]    led_q;
  state_e              state_q;
  logic [ShW-1:0]      shift_q;
  logic [ShW-1:0]      shift_next;
  logic [BitW-1:0]     bit_cnt_q;
  logic [BcdW-1:0]     bcd_q;
  logic                valid_q;
  logic [ScanW-1:0]    scan_cnt_q;
  logic [IdxW-1:0]     idx_q;
  logic [DIGITS-1:0]   anodo_q, anodo_d;
  logic [6:0]          catodo_q, catodo_d;
  logic [3:0]          nib_sel;
  logic                hi_zero;

  assign tick       = (samp_cnt_q == SampMax);
  assign shift_next = dabble_step(shift_q);

  // Two-flop synchroniser for the switch inputs and mode.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {mode_pi, codigo_gray_pi};
      sync2_q <= sync1_q;
    end
  end

  // Sample counter, binary register and LED register.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      samp_cnt_q <= '0;
      bin_q      <= '0;
      led_q      <= '1;
    end else begin
      samp_cnt_q <= tick ? '0 : samp_cnt_q + SampW'(1);
      if (tick) begin
        bin_q <= sync2_q[WIDTH] ? sync2_q[WIDTH-1:0] : gray2bin(sync2_q[WIDTH-1:0]);
      end
      led_q <= ~bin_q;
    end
  end

  // Conversion FSM; a tick outside StIdle is ignored.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tick) state_q <= StLoad;
        end
        StLoad: begin
          shift_q   <= {{BcdW{1'b0}}, bin_q};
          bit_cnt_q <= '0;
          state_q   <= StShift;
        end
        StShift: begin
          shift_q   <= shift_next;
          bit_cnt_q <= bit_cnt_q + BitW'(1);
          if (bit_cnt_q == BitMax) begin
            bcd_q   <= shift_next[ShW-1 -: BcdW];
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Select the scanned nibble and detect whether it and all higher nibbles are zero.
  always_comb begin
    nib_sel = '0;
    hi_zero = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (d == 32'(idx_q)) nib_sel = bcd_q[4*d +: 4];
      if ((d >= 32'(idx_q)) && (bcd_q[4*d +: 4] != 4'd0)) hi_zero = 1'b0;
    end
    anodo_d  = ~(DIGITS'(1) << idx_q);
    catodo_d = seg7(nib_sel);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q != '0) && hi_zero) catodo_d = SegBlank;
`endif
  end

  // Digit scan counter/index and registered display outputs.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      anodo_q    <= ~DIGITS'(1);
      catodo_q   <= SegZero;
    end else begin
      if (scan_cnt_q == ScanMax) begin
        scan_cnt_q <= '0;
        idx_q      <= (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
      end else begin
        scan_cnt_q <= scan_cnt_q + ScanW'(1);
      end
      anodo_q  <= anodo_d;
      catodo_q <= catodo_d;
    end
  end

  assign anodo_po          = anodo_q;
  assign catodo_po         = catodo_q;
  assign codigo_bin_led_po = led_q;
  assign bcd_valid_po      = valid_q;

  // hi_zero only feeds the optional leading-zero blanking.
  logic unused_hi_zero;
  assign unused_hi_zero = hi_zero;

endmodule
